ysyx_23060240_sram_slave: RTL
=============================

YSYX_23060240_SRAM_SLAVE -- requirements
Module: ysyx_23060240_sram_slave

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 2, wait cycles between request acceptance and response; legal range 0..15.
REQ-004 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  reset, asynchronous, active-low.
REQ-006 Port: araddr  in  32  read address; arvalid  in  1; arready  out  1.
REQ-007 Port: rdata  out  32  read data; rresp  out  2  (00 OKAY, 10 SLVERR); rvalid  out  1; rready  in  1.
REQ-008 Port: awaddr  in  32; awvalid  in  1; awready  out  1.
REQ-009 Port: wdata  in  32; wstrb  in  4  byte enables; wvalid  in  1; wready  out  1.
REQ-010 Port: bresp  out  2; bvalid  out  1; bready  in  1.

Function
REQ-011 SHALL serve the IFU/LSU request side: one outstanding transaction total, read or write.
REQ-012 FSM states SHALL be IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
REQ-013 In IDLE, a read request is arvalid=1; a write request is awvalid=1 and wvalid=1 in the same cycle; awvalid without wvalid (or the reverse) SHALL NOT be accepted.
REQ-014 Arbitration SHALL alternate when read and write requests are both present: grant the class not granted last; after reset, read wins first.
REQ-015 arready SHALL be combinationally high only in IDLE with read granted; awready and wready SHALL be high together only in IDLE with write granted; all three SHALL be 0 in every other state.
REQ-016 On acceptance, address, wdata and wstrb SHALL be registered; later changes on input buses SHALL have no effect.
REQ-017 Wait counter SHALL load LATENCY at acceptance and decrement once per WAIT cycle; leave WAIT when it reaches 0; LATENCY=0 SHALL go directly from IDLE to the RESP state.
REQ-018 rvalid/bvalid SHALL therefore rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-019 Word index SHALL be (addr-BASE)>>2; addr[1:0] ignored; address in range iff BASE <= addr < BASE+4*DEPTH, 32-bit unsigned compare.
REQ-020 Read: rdata SHALL be captured at entry to RD_RESP; in-range -> mem word, rresp=00; out-of-range -> rdata=0, rresp=10.
REQ-021 Write: at entry to WR_RESP, each byte i with wstrb[i]=1 SHALL be updated; wstrb=0000 is legal (no change, bresp=00); out-of-range -> no memory change, bresp=10.
REQ-022 rdata, rresp, rvalid SHALL hold stable in RD_RESP until rready=1; on rvalid&&rready return to IDLE next edge; same rule for bvalid/bready/bresp in WR_RESP.
REQ-023 A new request present in the cycle of the response handshake SHALL NOT be accepted before the following IDLE cycle (minimum one idle cycle between transactions).
REQ-024 Write followed by read of the same word SHALL return the updated data.
REQ-025 Memory array SHALL be a register array of DEPTH words, uninitialised, not reset.

Reset
REQ-026 rst=0 SHALL asynchronously force state IDLE, counter 0, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00, arbitration pointer to read-first.
REQ-027 Reset asserted mid-transaction SHALL abort it; a write not yet committed SHALL leave memory unchanged; memory contents SHALL otherwise survive reset.
REQ-028 After rst deassertion, arready SHALL be 1 in the first cycle that arvalid=1.

Verification
REQ-029 LATENCY=2: write 0x80000010 wdata=0xDEADBEEF wstrb=1111, bready=1 -> bvalid 3 cycles after accept, bresp=00; read same -> rdata=0xDEADBEEF, rresp=00.
REQ-030 Partial write: word holds 0x11223344, write wdata=0xAABBCCDD wstrb=0101 -> readback 0x11BB33DD.
REQ-031 Out-of-range: read 0x7FFF_FFFC -> rdata=0, rresp=10; write 0x8000_1000 (DEPTH=1024) -> bresp=10, word 0 unchanged.
REQ-032 Simultaneous arvalid and awvalid+wvalid held for two transactions -> read served first, then write; next collision -> read again.
REQ-033 rready held 0 for 5 cycles in RD_RESP -> rvalid and rdata stable all 5 cycles; arready stays 0.
REQ-034 rst pulsed low during WR_WAIT of write 0x0000_00FF to 0x80000020 -> bvalid never rises, subsequent read returns prior contents.

Source files
------------

// File: rtl/ysyx_23060240_sram_slave_if.sv
// ----------------------------------------------------------------------------
// ysyx_23060240_sram_slave_if
// Bus bundle between an IFU/LSU requester and the SRAM slave.
//   Read address : araddr, arvalid (to slave), arready (from slave)
//   Read data    : rdata, rresp, rvalid (from slave), rready (to slave)
//   Write address: awaddr, awvalid (to slave), awready (from slave)
//   Write data   : wdata, wstrb, wvalid (to slave), wready (from slave)
//   Write resp   : bresp, bvalid (from slave), bready (to slave)
// ----------------------------------------------------------------------------
interface ysyx_23060240_sram_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060240_sram_slave.sv
// ----------------------------------------------------------------------------
// ysyx_23060240_sram_slave
// Single-outstanding SRAM slave with a fixed response latency. Reads and
// writes share one transaction slot; on collision the class not granted last
// wins (read first after reset).
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - slave side of ysyx_23060240_sram_slave_if (AR/R/AW/W/B channels)
// Parameters:
//   BASE    - byte address of word 0
//   DEPTH   - number of 32-bit words
//   LATENCY - wait cycles between acceptance and response (0..15)
// ----------------------------------------------------------------------------
module ysyx_23060240_sram_slave #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_23060240_sram_slave_if.slave     bus
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT_L = 4'(LATENCY);
    localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic        pref_wr_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0]  wstrb_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r, bresp_r;
    logic        rvalid_r, bvalid_r;
    logic [31:0] mem_r [DEPTH];

    logic        rd_req_s, wr_req_s, grant_rd_s, grant_wr_s;
    logic        enter_rd_s, commit_s, in_rng_s;
    logic [31:0] cap_addr_s, cap_wdata_s, off_s, idx_full_s, rd_word_s;
    logic [3:0]  cap_wstrb_s;
    logic [AW-1:0] idx_s;
    logic        unused_s;

    // A write request needs both address and data in the same cycle.
    assign rd_req_s   = bus.arvalid;
    assign wr_req_s   = bus.awvalid & bus.wvalid;
    assign grant_rd_s = (state_r == IDLE) & rd_req_s & (~wr_req_s | ~pref_wr_r);
    assign grant_wr_s = (state_r == IDLE) & wr_req_s & (~rd_req_s | pref_wr_r);

    assign bus.arready = grant_rd_s;
    assign bus.awready = grant_wr_s;
    assign bus.wready  = grant_wr_s;

    // With LATENCY=0 the response is built on the acceptance edge itself, so
    // the live bus values are used in IDLE and the captured copies otherwise.
    assign cap_addr_s  = (state_r == IDLE) ? (grant_wr_s ? bus.awaddr : bus.araddr) : addr_r;
    assign cap_wdata_s = (state_r == IDLE) ? bus.wdata : wdata_r;
    assign cap_wstrb_s = (state_r == IDLE) ? bus.wstrb : wstrb_r;

    assign off_s      = cap_addr_s - BASE;
    assign in_rng_s   = (cap_addr_s >= BASE) & (off_s < SPAN);
    assign idx_full_s = off_s >> 2;
    assign idx_s      = idx_full_s[AW-1:0];
    assign rd_word_s  = mem_r[idx_s];
    // Byte-offset bits and index bits above the array size carry no meaning.
    assign unused_s   = ^{idx_full_s[31:AW], off_s[1:0]};

    assign enter_rd_s = (state_nxt_s == RD_RESP) & (state_r != RD_RESP);
    assign commit_s   = (state_nxt_s == WR_RESP) & (state_r != WR_RESP);

    assign bus.rdata  = rdata_r;
    assign bus.rresp  = rresp_r;
    assign bus.rvalid = rvalid_r;
    assign bus.bresp  = bresp_r;
    assign bus.bvalid = bvalid_r;

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (grant_rd_s) begin
                    cnt_nxt_s   = LAT_L;
                    state_nxt_s = (LAT_L == 4'd0) ? RD_RESP : RD_WAIT;
                end else if (grant_wr_s) begin
                    cnt_nxt_s   = LAT_L;
                    state_nxt_s = (LAT_L == 4'd0) ? WR_RESP : WR_WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = RD_RESP;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            WR_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    cnt_nxt_s   = 4'd0;
                    state_nxt_s = WR_RESP;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            RD_RESP: begin
                if (bus.rready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RD_RESP;
                end
            end
            WR_RESP: begin
                if (bus.bready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WR_RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Control state, request capture and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pref_wr_r <= 1'b0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
            rdata_r   <= 32'd0;
            rresp_r   <= 2'b00;
            bresp_r   <= 2'b00;
            rvalid_r  <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            rvalid_r <= (state_nxt_s == RD_RESP);
            bvalid_r <= (state_nxt_s == WR_RESP);
            // Alternate priority: after serving one class, favour the other.
            if (grant_rd_s) begin
                pref_wr_r <= 1'b1;
            end else if (grant_wr_s) begin
                pref_wr_r <= 1'b0;
            end
            if (grant_rd_s | grant_wr_s) begin
                addr_r  <= cap_addr_s;
                wdata_r <= bus.wdata;
                wstrb_r <= bus.wstrb;
            end
            if (enter_rd_s) begin
                rdata_r <= in_rng_s ? rd_word_s : 32'd0;
                rresp_r <= in_rng_s ? 2'b00 : 2'b10;
            end
            if (commit_s) begin
                bresp_r <= in_rng_s ? 2'b00 : 2'b10;
            end
        end
    end

    // Storage array: byte-masked commit on entry to the write response; never reset.
    always_ff @(posedge clk) begin
        if (commit_s && in_rng_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_wstrb_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= cap_wdata_s[8*i +: 8];
                end
            end
        end
    end

endmodule
